// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 byte stream demultiplexer.
package demux_pkg;

  localparam int DW_DEF = 8;
  localparam int DEPTH  = 2;

  typedef logic [DW_DEF-1:0] beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  // Occupancy step for a 2-entry FIFO; push+pop together holds the state.
  function automatic fifo_state_t next_fifo_state(input fifo_state_t cur,
                                                  input logic        do_push,
                                                  input logic        do_pop);
    fifo_state_t nxt;
    nxt = cur;
    case ({do_push, do_pop})
      2'b10:   nxt = (cur == EMPTY) ? ONE : FULL;
      2'b01:   nxt = (cur == FULL) ? ONE : EMPTY;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fifo2_8bit.sv
// Two-entry byte FIFO with 1-bit wrapping pointers and registered head.
// Push is refused when full and pop is refused when empty, so the caller
// may present requests without pre-qualifying them.
module fifo2_8bit
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DW_DEF-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DW_DEF-1:0] head
);

  fifo_state_t state_q, state_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  beat_t       mem_q [DEPTH];
  beat_t       mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full  = (state_q == FULL);
  assign empty = (state_q == EMPTY);
  assign head  = mem_q[rd_ptr_q];

  // Next-state: write at wr_ptr, advance pointers, step the occupancy.
  always_comb begin
    do_push  = push && (state_q != FULL);
    do_pop   = pop && (state_q != EMPTY);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    state_d = next_fifo_state(state_q, do_push, do_pop);
  end

  // State registers; reset clears storage so the head reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/demux1x2_stream_8bit.sv
// Registered 1-to-2 byte stream demultiplexer: steers each input beat by
// in_sel into one of two 2-entry output FIFOs and counts beats per output.
module demux1x2_stream_8bit
  import demux_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [DW-1:0] out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [DW-1:0] out1_data,
  output logic [7:0]    cnt0,
  output logic [7:0]    cnt1
);

  logic       full0, full1;
  logic       empty0, empty1;
  logic       accept;
  logic       push0, push1;
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  // Readiness depends only on the selected FIFO's registered fullness,
  // so a full FIFO never passes a beat through even if it pops this cycle.
  assign in_ready = in_sel ? ~full1 : ~full0;
  assign accept   = in_valid & in_ready;
  assign push0    = accept & ~in_sel;
  assign push1    = accept & in_sel;

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

  fifo2_8bit u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .full      (full0),
    .empty     (empty0),
    .head      (out0_data)
  );

  fifo2_8bit u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .full      (full1),
    .empty     (empty1),
    .head      (out1_data)
  );

  // Per-output accepted-beat counters, wrapping modulo 256.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (push0) begin
      cnt0_d = cnt0_q + 8'd1;
    end
    if (push1) begin
      cnt1_d = cnt1_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_demux1x2_stream_8bit.sv
// Self-checking bench for demux1x2_stream_8bit: queue-based reference model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized traffic phase.
module tb_demux1x2_stream_8bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sel;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out0_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out1_data;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         mcnt0 = 0;
  int         mcnt1 = 0;
  bit         acc0, acc1, pop0, pop1;

  demux1x2_stream_8bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setInputs(input logic v, input logic s, input logic [7:0] d,
                           input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d,
                               input logic r0, input logic r1);
    setInputs(v, s, d, r0, r1);
    @(posedge clk);
    #1;
  endtask

  // Reference model: two bounded queues and two counters, advanced per edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mcnt0 = 0;
      mcnt1 = 0;
    end else begin
      acc0 = in_valid && !in_sel && (q0.size() < 2);
      acc1 = in_valid && in_sel && (q1.size() < 2);
      pop0 = out0_ready && (q0.size() > 0);
      pop1 = out1_ready && (q1.size() > 0);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (acc0) begin
        q0.push_back(in_data);
        mcnt0 = (mcnt0 + 1) % 256;
      end
      if (acc1) begin
        q1.push_back(in_data);
        mcnt1 = (mcnt1 + 1) % 256;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      checkOutput("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) checkOutput("out0_data", 32'(out0_data), 32'(q0[0]));
      if (q1.size() != 0) checkOutput("out1_data", 32'(out1_data), 32'(q1[0]));
      checkOutput("cnt0", 32'(cnt0), 32'(mcnt0));
      checkOutput("cnt1", 32'(cnt1), 32'(mcnt1));
      checkOutput("in_ready", 32'(in_ready),
                  32'(in_sel ? (q1.size() < 2) : (q0.size() < 2)));
    end
  end

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;

    // Reset held two cycles with a beat offered.
    applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
    check_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
    checkOutput("rst_out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("rst_out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("rst_out0_data", 32'(out0_data), 32'd0);
    checkOutput("rst_out1_data", 32'(out1_data), 32'd0);
    checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
    checkOutput("rst_cnt1", 32'(cnt1), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("post_rst_out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("post_rst_out1_valid", 32'(out1_valid), 32'd0);

    // Steering to each output.
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    checkOutput("steer_out0_valid", 32'(out0_valid), 32'd1);
    checkOutput("steer_out0_data", 32'(out0_data), 32'hA5);
    checkOutput("steer_cnt0", 32'(cnt0), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    checkOutput("steer_out1_data", 32'(out1_data), 32'h3C);
    checkOutput("steer_cnt1", 32'(cnt1), 32'd1);
    checkOutput("steer_out0_drained", 32'(out0_valid), 32'd0);

    // Backpressure on out0 while out1 keeps flowing.
    applyStimulus(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
    setInputs(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
    #1;
    checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
    checkOutput("bp_cnt0_stalled", 32'(cnt0), 32'd3);
    setInputs(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    #1;
    checkOutput("bp_in_ready_other", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("bp_out1_data", 32'(out1_data), 32'h77);
    checkOutput("bp_out0_head", 32'(out0_data), 32'h01);
    checkOutput("bp_cnt1", 32'(cnt1), 32'd2);

    // Full FIFO with a pop in the same cycle: no pass-through.
    setInputs(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    #1;
    checkOutput("fullpop_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    checkOutput("fullpop_in_ready_next", 32'(in_ready), 32'd1);
    checkOutput("fullpop_head", 32'(out0_data), 32'h02);
    checkOutput("fullpop_cnt0", 32'(cnt0), 32'd3);
    applyStimulus(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    checkOutput("order_head3", 32'(out0_data), 32'h03);
    checkOutput("order_cnt0", 32'(cnt0), 32'd4);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("order_drained", 32'(out0_valid), 32'd0);

    // Counter wrap over 256 beats to out1.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
      if (i == 254) checkOutput("wrap_cnt1_255", 32'(cnt1), 32'd255);
    end
    checkOutput("wrap_cnt1_0", 32'(cnt1), 32'd0);
    checkOutput("wrap_cnt0_0", 32'(cnt0), 32'd0);
    checkOutput("wrap_last_data", 32'(out1_data), 32'hFF);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Reset mid-stream flushes buffered beats.
    applyStimulus(1'b1, 1'b1, 8'hD1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hD2, 1'b1, 1'b0);
    checkOutput("mid_out1_valid", 32'(out1_valid), 32'd1);
    checkOutput("mid_out1_head", 32'(out1_data), 32'hD1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;
    checkOutput("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("mid_rst_cnt1", 32'(cnt1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("mid_no_replay", 32'(out1_valid), 32'd0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 127) != 0);
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    end
    checkOutput("final_out0_empty", 32'(out0_valid), 32'd0);
    checkOutput("final_out1_empty", 32'(out1_valid), 32'd0);

    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
